tl_cmd_scheduler: RTL and testbench

Command scheduler in front of the traffic_lights command port (cmd_type/cmd_valid/cmd_data).
- Round-robin arbitration among REQ_NUM requesters, e.g. operator console, remote link, maintenance timer.
- Buffers granted commands in a small FIFO.
- Issues them to the light controller as single-cycle pulses, with a guaranteed idle gap between pulses.
- Rejects illegal command codes.

---
 rtl/tl_pkg.sv | 37 +++
 rtl/tl_cmd_fifo.sv | 71 +++++++
 rtl/tl_cmd_scheduler.sv | 165 ++++++++++++++++
 tb/tb_tl_cmd_scheduler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// -----------------------------------------------------------------------------
// tl_pkg
// Shared types for the traffic-lights command path: the command code enum,
// the {type,data} command word carried through the scheduler FIFO, the
// issuer state encoding and a legality helper.
// -----------------------------------------------------------------------------
package tl_pkg;

    typedef enum logic [2:0] {
        TL_TURN_ON         = 3'd0,
        TL_TURN_OFF        = 3'd1,
        TL_SET_UNCONTR     = 3'd2,
        TL_SET_GREEN_TIME  = 3'd3,
        TL_SET_RED_TIME    = 3'd4,
        TL_SET_YELLOW_TIME = 3'd5
    } tl_cmd_e;

    // Codes at or above this value have no meaning to the light controller.
    localparam logic [2:0] TL_CMD_ILLEGAL_MIN = 3'd6;

    // Raw 3-bit field rather than tl_cmd_e so illegal codes can be carried.
    typedef struct packed {
        logic [2:0]  cmd_type;
        logic [15:0] data;
    } tl_cmd_t;

    typedef enum logic [1:0] {
        TL_ST_IDLE  = 2'd0,
        TL_ST_ISSUE = 2'd1,
        TL_ST_GAP   = 2'd2
    } tl_iss_state_e;

    function automatic logic tl_is_legal(input logic [2:0] t);
        return t < TL_CMD_ILLEGAL_MIN;
    endfunction

endpackage

// File: rtl/tl_cmd_fifo.sv
// -----------------------------------------------------------------------------
// tl_cmd_fifo
// Synchronous FIFO of tl_cmd_t with registered storage and occupancy count.
// Ports:
//   clk_i, srst_n_i   clock, synchronous active-low reset
//   flush_i           drop all entries (wins over push/pop)
//   push_i, din_i     write request / data (ignored when full)
//   pop_i, dout_o     read request / head entry (dout_o valid when !empty_o)
//   full_o, empty_o   status
//   level_o           current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module tl_cmd_fifo
    import tl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     srst_n_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  tl_cmd_t                  din_i,
    input  logic                     pop_i,
    output tl_cmd_t                  dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    tl_cmd_t       mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   lvl_q, lvl_d;
    logic          do_push, do_pop;

    assign full_o  = (lvl_q == (AW+1)'(DEPTH));
    assign empty_o = (lvl_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q];
    assign level_o = lvl_q;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_comb begin
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        lvl_d = lvl_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            lvl_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
    end

    // Storage needs no reset: entries are only read below the level count.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/tl_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// tl_cmd_scheduler
// Round-robin arbiter over REQ_NUM command sources feeding a small FIFO, and
// an issuer that drives the light controller with single-cycle command pulses
// separated by at least CMD_GAP idle cycles. Illegal codes are accepted,
// dropped and flagged on err_illegal_o.
// Optional feature macro: TL_CMD_OFF_PREEMPT_EN -- an accepted TURN_OFF
// flushes the FIFO, bypasses it and is issued at the next IDLE, cutting short
// any remaining gap.
// Ports:
//   clk_i, srst_n_i           clock, synchronous active-low reset
//   req_valid/type/data_i     per-requester command, held until accepted
//   req_ready_o               one-hot accept (or zero)
//   cmd_type/data/valid_o     command strobe to light controller
//   err_illegal_o             one-cycle pulse after an illegal accept
//   fifo_level_o              FIFO occupancy
// -----------------------------------------------------------------------------
module tl_cmd_scheduler
    import tl_pkg::*;
#(
    parameter int REQ_NUM    = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int CMD_GAP    = 2
) (
    input  logic                            clk_i,
    input  logic                            srst_n_i,
    input  logic [REQ_NUM-1:0]              req_valid_i,
    input  logic [REQ_NUM-1:0][2:0]         req_type_i,
    input  logic [REQ_NUM-1:0][15:0]        req_data_i,
    output logic [REQ_NUM-1:0]              req_ready_o,
    output logic [2:0]                      cmd_type_o,
    output logic [15:0]                     cmd_data_o,
    output logic                            cmd_valid_o,
    output logic                            err_illegal_o,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o
);
    localparam int PW = $clog2(REQ_NUM);
    localparam int GW = 4;

    // ptr_q is where the next search starts, i.e. one past the last grant.
    logic [PW-1:0] ptr_q, ptr_d, gnt_idx;
    logic          gnt_found, hs, hs_legal, off_hs;
    tl_cmd_t       hs_cmd, fifo_dout, cmd_q, pend_q;
    logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
    tl_iss_state_e state_q;
    logic [GW-1:0] gap_q;
    logic          cmd_valid_q, pend_v_q, err_q;

    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            idx = PW'((int'(ptr_q) + i) % REQ_NUM);
            if (!gnt_found && req_valid_i[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    // Ready is gated by reset so no handshake can complete during reset.
    assign hs = srst_n_i && gnt_found && !fifo_full;

    always_comb begin
        req_ready_o = '0;
        if (hs) req_ready_o[gnt_idx] = 1'b1;
    end

    assign hs_cmd   = '{cmd_type: req_type_i[gnt_idx], data: req_data_i[gnt_idx]};
    assign hs_legal = tl_is_legal(hs_cmd.cmd_type);
    assign ptr_d    = !hs ? ptr_q :
                      (gnt_idx == PW'(REQ_NUM - 1)) ? '0 : gnt_idx + PW'(1);

`ifdef TL_CMD_OFF_PREEMPT_EN
    assign off_hs = hs && (hs_cmd.cmd_type == 3'(TL_TURN_OFF));
`else
    assign off_hs = 1'b0;
`endif

    // A preempting TURN_OFF never enters the FIFO and blocks this cycle's pop,
    // so nothing queued ahead of it can slip out afterwards.
    assign fifo_push = hs && hs_legal && !off_hs;
    assign fifo_pop  = (state_q == TL_ST_IDLE) && !off_hs && !pend_v_q && !fifo_empty;

    tl_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i    (clk_i),
        .srst_n_i (srst_n_i),
        .flush_i  (off_hs),
        .push_i   (fifo_push),
        .din_i    (hs_cmd),
        .pop_i    (fifo_pop),
        .dout_o   (fifo_dout),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .level_o  (fifo_level_o)
    );

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            err_q <= hs && !hs_legal;
        end
    end

    // Issuer: command register is cleared every cycle it is not being loaded,
    // which keeps type/data at zero outside the strobe.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_q     <= TL_ST_IDLE;
            gap_q       <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_q      <= '0;
        end else begin
            cmd_valid_q <= 1'b0;
            cmd_q       <= '0;
            if (off_hs) begin
                pend_v_q <= 1'b1;
                pend_q   <= hs_cmd;
            end
            unique case (state_q)
                TL_ST_IDLE: begin
                    if (!off_hs) begin
                        if (pend_v_q) begin
                            cmd_q       <= pend_q;
                            cmd_valid_q <= 1'b1;
                            pend_v_q    <= 1'b0;
                            state_q     <= TL_ST_ISSUE;
                        end else if (!fifo_empty) begin
                            cmd_q       <= fifo_dout;
                            cmd_valid_q <= 1'b1;
                            state_q     <= TL_ST_ISSUE;
                        end
                    end
                end
                TL_ST_ISSUE: begin
                    if (CMD_GAP > 0) begin
                        state_q <= TL_ST_GAP;
                        gap_q   <= GW'(CMD_GAP - 1);
                    end else begin
                        state_q <= TL_ST_IDLE;
                    end
                end
                TL_ST_GAP: begin
                    // A pending TURN_OFF abandons the rest of the gap.
                    if (pend_v_q || gap_q == '0) state_q <= TL_ST_IDLE;
                    else                         gap_q   <= gap_q - GW'(1);
                end
                default: state_q <= TL_ST_IDLE;
            endcase
        end
    end

    assign cmd_type_o    = cmd_q.cmd_type;
    assign cmd_data_o    = cmd_q.data;
    assign cmd_valid_o   = cmd_valid_q;
    assign err_illegal_o = err_q;

endmodule

// File: tb/tb_tl_cmd_scheduler.sv
module tb_tl_cmd_scheduler;
  import tl_pkg::*;

  localparam int N = 3, D = 4, GAP = 2;

  logic              clk = 1'b0, srst_n;
  logic [N-1:0]      req_valid, req_ready;
  logic [N-1:0][2:0] req_type;
  logic [N-1:0][15:0] req_data;
  logic [2:0]        cmd_type;
  logic [15:0]       cmd_data;
  logic              cmd_valid, err_illegal;
  logic [$clog2(D):0] fifo_level;

  int vectors = 0, miscompares = 0;

  // model: queue of accepted commands, issuer busy countdown, pointer
  logic [18:0] q[$];
  int          ptr, busy;
  logic        exp_v, exp_err, pend_v;
  logic [18:0] exp_cmd, pend;

  // observation logs
  logic [18:0] issued[$];
  int          issue_cyc[$], acc_g[$];
  int          cyc, last_hs_cyc, legal_acc, err_cnt, max_lvl, stall;
  int          p_new[N];
  int          ill_pct;

  always #5 clk = ~clk;

  tl_cmd_scheduler #(.REQ_NUM(N), .FIFO_DEPTH(D), .CMD_GAP(GAP)) dut (
    .clk_i(clk), .srst_n_i(srst_n),
    .req_valid_i(req_valid), .req_type_i(req_type), .req_data_i(req_data),
    .req_ready_o(req_ready), .cmd_type_o(cmd_type), .cmd_data_o(cmd_data),
    .cmd_valid_o(cmd_valid), .err_illegal_o(err_illegal), .fifo_level_o(fifo_level)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic new_cmd(input int i);
    req_type[i]  = ($urandom_range(0, 99) < ill_pct) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
    req_data[i]  = 16'($urandom);
    req_valid[i] = 1'b1;
  endtask

  task automatic put(input int i, input logic [2:0] t, input logic [15:0] d);
    req_type[i] = t; req_data[i] = d; req_valid[i] = 1'b1;
  endtask

  // one clock: check outputs at negedge, advance model across posedge, drive
  task automatic step();
    int g;
    logic [N-1:0] rdy;
    logic [18:0] c;
    logic hs, hs_off;
    @(negedge clk);
    cyc++;
    g = -1;
    for (int i = 0; i < N; i++) if (g < 0 && req_valid[(ptr + i) % N]) g = (ptr + i) % N;
    rdy = '0; hs = 1'b0;
    if (srst_n && g >= 0 && q.size() < D) begin rdy[g] = 1'b1; hs = 1'b1; end
    chk("ready", req_ready, rdy);
    chk("valid", cmd_valid, exp_v);
    chk("cmd", {cmd_type, cmd_data}, exp_cmd);
    chk("err", err_illegal, exp_err);
    chk("level", fifo_level, q.size());
    if (cmd_valid) begin issued.push_back({cmd_type, cmd_data}); issue_cyc.push_back(cyc); end
    if (err_illegal) err_cnt++;
    if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
    if (req_valid[1] && !req_ready[1] && fifo_level == D) stall++;

    c = hs ? {req_type[g], req_data[g]} : 19'd0;
    if (hs) begin last_hs_cyc = cyc; acc_g.push_back(g); end
    hs_off = 1'b0;
`ifdef TL_CMD_OFF_PREEMPT_EN
    hs_off = hs && (c[18:16] == 3'd1);
`endif
    exp_v = 1'b0; exp_cmd = '0;
    if (!srst_n) begin
      q.delete(); ptr = 0; busy = 0; pend_v = 1'b0; exp_err = 1'b0;
    end else begin
      // issuer free: launch a pulse next cycle, then stay busy for ISSUE + gap
      if (busy == 0) begin
        if (!hs_off) begin
          if (pend_v) begin exp_v = 1'b1; exp_cmd = pend; pend_v = 1'b0; busy = 1 + GAP; end
          else if (q.size() > 0) begin exp_v = 1'b1; exp_cmd = q.pop_front(); busy = 1 + GAP; end
        end
      end else if (pend_v && busy <= GAP) busy = 0;
      else busy--;
      exp_err = hs && (c[18:16] >= 3'd6);
      if (hs_off) begin q.delete(); pend_v = 1'b1; pend = c; end
      else if (hs && c[18:16] < 3'd6) begin q.push_back(c); legal_acc++; end
      if (hs) ptr = (g + 1) % N;
    end

    @(posedge clk); #1;
    if (hs) req_valid[g] = 1'b0;
    for (int i = 0; i < N; i++)
      if (!req_valid[i] && $urandom_range(0, 99) < p_new[i]) new_cmd(i);
  endtask

  task automatic do_reset();
    srst_n = 1'b0; req_valid = '0;
    for (int i = 0; i < N; i++) p_new[i] = 0;
    step(); step();
    srst_n = 1'b1;
    issued.delete(); issue_cyc.delete(); acc_g.delete();
    legal_acc = 0; err_cnt = 0; max_lvl = 0; stall = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    for (int i = 0; i < N; i++) p_new[i] = 0;
    while (((|req_valid) || q.size() != 0 || busy != 0 || pend_v) && n < 300) begin step(); n++; end
    if (n >= 300) chk("drain_timeout", 0, 1);
    repeat (3) step();
  endtask

  initial begin
    int n, pos, exp_pos, exp_cnt;
    srst_n = 1'b0; req_valid = '0; req_type = '0; req_data = '0; ill_pct = 0;
    q.delete(); ptr = 0; busy = 0; exp_v = 0; exp_err = 0; pend_v = 0; exp_cmd = '0; pend = '0;
    cyc = 0; last_hs_cyc = 0;
    for (int i = 0; i < N; i++) p_new[i] = 0;
    repeat (2) @(posedge clk); #1;
    do_reset();
    chk("rst_valid", cmd_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_err", err_illegal, 0);
    chk("rst_cmd", {cmd_type, cmd_data}, 0);

    // 1: single SET_RED_TIME, two-cycle latency
    put(0, 3'd4, 16'd10);
    drain();
    chk("t1_cnt", issued.size(), 1);
    if (issued.size() > 0) begin
      chk("t1_cmd", issued[0], {3'd4, 16'd10});
      chk("t1_lat", issue_cyc[0] - last_hs_cyc, 2);
    end

    // 2: three simultaneous requesters, RR order and pulse spacing
    do_reset();
    put(0, 3'd3, 16'd7); put(1, 3'd4, 16'd8); put(2, 3'd5, 16'd9);
    drain();
    chk("t2_acc_cnt", acc_g.size(), 3);
    chk("t2_cnt", issued.size(), 3);
    for (int k = 0; k < 3 && k < acc_g.size(); k++) chk("t2_acc_order", acc_g[k], k);
    for (int k = 0; k < 3 && k < issued.size(); k++) chk("t2_iss_order", issued[k], {3'(3 + k), 16'(7 + k)});
    for (int k = 1; k < 3 && k < issue_cyc.size(); k++) chk("t2_spacing", issue_cyc[k] - issue_cyc[k-1], 2 + GAP);

    // 3: requester 1 streams continuously, FIFO fills and back-pressures
    do_reset();
    ill_pct = 0; p_new[1] = 100;
    repeat (40) step();
    chk("t3_maxlvl", max_lvl, D);
    chk("t3_stalled", stall > 0, 1);
    drain();
    chk("t3_cnt", issued.size(), legal_acc);

    // 4: illegal code is accepted, flagged, not issued
    do_reset();
    put(2, 3'd7, 16'h1234);
    drain();
    chk("t4_acc", acc_g.size(), 1);
    chk("t4_err", err_cnt, 1);
    chk("t4_iss", issued.size(), 0);

    // 5: reset during ISSUE with entries queued
    do_reset();
    for (int i = 0; i < N; i++) p_new[i] = 100;
    n = 0;
    while (!(cmd_valid && fifo_level == 3) && n < 200) begin step(); n++; end
    if (n >= 200) chk("t5_timeout", 0, 1);
    srst_n = 1'b0; req_valid = '0;
    for (int i = 0; i < N; i++) p_new[i] = 0;
    step();
    srst_n = 1'b1;
    chk("t5_valid", cmd_valid, 0);
    chk("t5_level", fifo_level, 0);
    issued.delete();
    repeat (20) step();
    chk("t5_quiet", issued.size(), 0);

    // 6: TURN_OFF behind three SETs
    do_reset();
    put(0, 3'd3, 16'd1); put(1, 3'd4, 16'd2); put(2, 3'd5, 16'd3);
    n = 0;
    while (acc_g.size() < 3 && n < 50) begin step(); n++; end
    if (n >= 50) chk("t6_timeout", 0, 1);
    put(0, 3'd1, 16'hdead);
    drain();
`ifdef TL_CMD_OFF_PREEMPT_EN
    exp_pos = 1; exp_cnt = 2;
`else
    exp_pos = 3; exp_cnt = 4;
`endif
    pos = -1;
    for (int k = 0; k < issued.size(); k++) if (pos < 0 && issued[k][18:16] == 3'd1) pos = k;
    chk("t6_off_pos", pos, exp_pos);
    chk("t6_cnt", issued.size(), exp_cnt);

    // randomized traffic against the model
    do_reset();
    ill_pct = 15;
    for (int i = 0; i < N; i++) p_new[i] = 30;
    repeat (1500) step();
    drain();
`ifndef TL_CMD_OFF_PREEMPT_EN
    chk("rand_cnt", issued.size(), legal_acc);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
